// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the mini CPU sequencer
package cpu_pkg;
   localparam logic [1:0] CLS_ALU = 2'b00;
   localparam logic [1:0] CLS_LDI = 2'b01;
   localparam logic [1:0] CLS_JNZ = 2'b10;
   localparam logic [1:0] CLS_HLT = 2'b11;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;
   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT} state_e;
   localparam int F_CLS = 8;
   localparam int F_OP  = 6;
   localparam int F_RD  = 4;
   localparam int F_RS1 = 2;
   localparam int F_RS2 = 0;
   function automatic logic [1:0] fld(input logic [9:0] w, input int pos);
      return w[pos +: 2];
   endfunction
endpackage

// File: rtl/cpu_if.sv
// cpu_if: instruction-fetch handshake and ALU operand/result bus
interface cpu_if #(parameter int PC_W = 4, parameter int IW = 10);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [IW-1:0]   imem_data;
   logic [1:0]      alu_opcode;
   logic [3:0]      alu_a;
   logic [3:0]      alu_b;
   logic [3:0]      alu_result;
   modport master (output imem_req, imem_addr, alu_opcode, alu_a, alu_b,
                   input  imem_ack, imem_data, alu_result);
   modport slave  (input  imem_req, imem_addr, alu_opcode, alu_a, alu_b,
                   output imem_ack, imem_data, alu_result);
endinterface

// File: rtl/cpu_regfile.sv
// cpu_regfile: 4x4-bit register file, two read ports, debug port, one write port
module cpu_regfile (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [1:0] wa,
   input  logic [3:0] wd,
   input  logic [1:0] ra1,
   input  logic [1:0] ra2,
   input  logic [1:0] dsel,
   output logic [3:0] rd1,
   output logic [3:0] rd2,
   output logic [3:0] ddata
);
   logic [3:0] rf [4];
   // single synchronous write, whole file cleared by reset
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < 4; i++) rf[i] <= '0;
      else if (we) rf[wa] <= wd;
   assign rd1   = rf[ra1];
   assign rd2   = rf[ra2];
   assign ddata = rf[dsel];
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller driving the 4-bit ALU
module cpu_sequencer import cpu_pkg::*; #(
   parameter int PC_W = 4,
   parameter int IW   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   cpu_if.master      bus,
   output logic       busy,
   output logic       halted,
   input  logic [1:0] dbg_sel,
   output logic [3:0] dbg_data
);
   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_FETCH  = ST_FETCH;
   localparam logic [2:0] S_DECODE = ST_DECODE;
   localparam logic [2:0] S_EXEC   = ST_EXEC;
   localparam logic [2:0] S_HALT   = ST_HALT;
   logic [2:0]      state;
   logic [PC_W-1:0] pc;
   logic [IW-1:0]   ir;
   logic [1:0]      cls, rd, rs1, rs2;
   logic [3:0]      rd1, rd2, wd;
   logic            we, jmp;
   assign cls = fld(ir[9:0], F_CLS);
   assign rd  = fld(ir[9:0], F_RD);
   assign rs1 = fld(ir[9:0], F_RS1);
   assign rs2 = fld(ir[9:0], F_RS2);
   assign we  = state == S_EXEC && (cls == CLS_ALU || cls == CLS_LDI);
   assign wd  = cls == CLS_LDI ? ir[3:0] : bus.alu_result;
   assign jmp = cls == CLS_JNZ && rd1 != 4'd0;
   assign bus.imem_req  = state == S_FETCH;
   assign bus.imem_addr = pc;
   assign busy   = state == S_FETCH || state == S_DECODE || state == S_EXEC;
   assign halted = state == S_HALT;
   // port 1 reads rs1 while decoding and rd (the JNZ test register) while executing
   cpu_regfile u_rf (
      .clk(clk), .rst(rst), .we(we), .wa(rd), .wd(wd),
      .ra1(state == S_EXEC ? rd : rs1), .ra2(rs2), .dsel(dbg_sel),
      .rd1(rd1), .rd2(rd2), .ddata(dbg_data)
   );
   // control FSM with PC, IR and the registered ALU operands
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state          <= S_IDLE;
         pc             <= '0;
         ir             <= '0;
         bus.alu_opcode <= '0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
      end else
         case (state)
            S_IDLE, S_HALT: if (start) begin
               pc    <= '0;
               state <= S_FETCH;
            end
            S_FETCH: if (bus.imem_ack) begin
               ir    <= bus.imem_data;
               state <= S_DECODE;
            end
            S_DECODE: begin
               bus.alu_opcode <= fld(ir[9:0], F_OP);
               bus.alu_a      <= rd1;
               bus.alu_b      <= rd2;
               state          <= S_EXEC;
            end
            S_EXEC: begin
               pc    <= cls == CLS_HLT ? pc : jmp ? PC_W'(ir[3:0]) : pc + 1'b1;
               state <= cls == CLS_HLT ? S_HALT : S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed programs checked against an instruction-level model
module tb_cpu_sequencer;
   import cpu_pkg::*;
   logic       clk = 0, rst = 1, start = 0;
   logic       busy, halted;
   logic [1:0] dbg_sel, rsel = 0, cyc = 0;
   logic       sel_ovr = 0, spurious = 0, clr = 0;
   logic [3:0] dbg_data;
   logic [9:0] mem [16];
   int         ack_delay = 0, wcnt = 0;
   int         n_chk = 0, n_fail = 0;
   int         fcnt [16];
   int         after15 = -1;
   logic       prev15 = 0;
   logic [3:0] last_addr;

   cpu_if #(.PC_W(4), .IW(10)) bus ();
   cpu_sequencer #(.PC_W(4), .IW(10)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy),
      .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #10 clk = ~clk;

   function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? (a & b) : (a | b);
   endfunction
   function automatic logic [9:0] ldi(input logic [1:0] r, input logic [3:0] imm);
      return {CLS_LDI, 2'b00, r, imm};
   endfunction
   function automatic logic [9:0] alu(input logic [1:0] op, input logic [1:0] r, input logic [1:0] s1, input logic [1:0] s2);
      return {CLS_ALU, op, r, s1, s2};
   endfunction
   function automatic logic [9:0] jnz(input logic [1:0] r, input logic [3:0] t);
      return {CLS_JNZ, 2'b00, r, t};
   endfunction
   localparam logic [9:0] HLT = {CLS_HLT, 8'h00};

   assign bus.imem_data  = mem[bus.imem_addr];
   assign bus.alu_result = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
   assign dbg_sel        = sel_ovr ? rsel : cyc;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // instruction memory responder: ack after ack_delay wait cycles, optional stray acks
   always @(negedge clk)
      if (bus.imem_req && !rst) begin
         bus.imem_ack <= wcnt >= ack_delay;
         wcnt         <= wcnt >= ack_delay ? 0 : wcnt + 1;
      end else begin
         bus.imem_ack <= spurious;
         wcnt         <= 0;
      end

   // fetch statistics and debug-select rotation
   always @(posedge clk) begin
      cyc <= cyc + 1'b1;
      if (clr) begin
         for (int i = 0; i < 16; i++) fcnt[i] <= 0;
         after15 <= -1;
         prev15  <= 0;
      end else if (bus.imem_req && bus.imem_ack) begin
         fcnt[bus.imem_addr] <= fcnt[bus.imem_addr] + 1;
         last_addr <= bus.imem_addr;
         prev15    <= bus.imem_addr == 4'd15;
         if (prev15 && after15 < 0) after15 <= int'(bus.imem_addr);
      end
   end

   // instruction-level model: fetch completes on ack, operands visible one edge
   // later, architectural effect one edge after that
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
   int         m_mode, m_ph;
   logic [3:0] m_pc, m_a, m_b;
   logic [9:0] m_ir;
   logic [1:0] m_op;
   logic [3:0] m_rf [4];
   always @(posedge clk or posedge rst)
      if (rst) begin
         m_mode <= M_IDLE; m_ph <= 0; m_pc <= 0; m_ir <= 0;
         m_op <= 0; m_a <= 0; m_b <= 0;
         for (int i = 0; i < 4; i++) m_rf[i] <= 0;
      end else if (m_mode != M_RUN) begin
         if (start) begin m_mode <= M_RUN; m_pc <= 0; m_ph <= 0; end
      end else if (m_ph == 0) begin
         if (bus.imem_ack) begin m_ir <= mem[m_pc]; m_ph <= 1; end
      end else if (m_ph == 1) begin
         m_op <= m_ir[7:6]; m_a <= m_rf[m_ir[3:2]]; m_b <= m_rf[m_ir[1:0]]; m_ph <= 2;
      end else begin
         m_ph <= 0;
         case (m_ir[9:8])
            CLS_ALU: begin m_rf[m_ir[5:4]] <= alu_f(m_op, m_a, m_b); m_pc <= m_pc + 1; end
            CLS_LDI: begin m_rf[m_ir[5:4]] <= m_ir[3:0]; m_pc <= m_pc + 1; end
            CLS_JNZ: m_pc <= m_rf[m_ir[5:4]] != 0 ? m_ir[3:0] : m_pc + 1;
            default: m_mode <= M_HALT;
         endcase
      end

   // per-cycle comparison of every output against the model
   always @(negedge clk)
      if (!rst) begin
         check("imem_req", bus.imem_req, m_mode == M_RUN && m_ph == 0);
         check("imem_addr", bus.imem_addr, m_pc);
         check("busy", busy, m_mode == M_RUN);
         check("halted", halted, m_mode == M_HALT);
         check("dbg_data", dbg_data, m_rf[dbg_sel]);
         check("alu_opcode", bus.alu_opcode, m_op);
         check("alu_a", bus.alu_a, m_a);
         check("alu_b", bus.alu_b, m_b);
      end

   task automatic pulse_start();
      @(negedge clk); start = 1;
      @(posedge clk); #1 start = 0;
   endtask
   task automatic check_reg(input string name, input logic [1:0] r, input logic [3:0] exp);
      sel_ovr = 1; rsel = r;
      #1 check(name, dbg_data, exp);
      sel_ovr = 0;
   endtask
   task automatic wait_halt(input int maxc);
      int n = 0;
      while (!halted && n < maxc) begin @(posedge clk); #1; n++; end
      check("halt_reached", halted, 1'b1);
   endtask
   task automatic clear_stats();
      @(posedge clk); #1 clr = 1;
      @(posedge clk); #1 clr = 0;
   endtask
   task automatic fill_hlt();
      for (int i = 0; i < 16; i++) mem[i] = HLT;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      fill_hlt();
      repeat (2) @(negedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      check("idle_req", bus.imem_req, 1'b0);
      check("idle_busy", busy, 1'b0);
      // LDI r1,7; LDI r2,9; ADD r3,r1,r2; HLT
      mem[0] = ldi(1, 7); mem[1] = ldi(2, 9); mem[2] = alu(OP_ADD, 3, 1, 2); mem[3] = HLT;
      pulse_start();
      repeat (8) @(posedge clk); #1;
      check("add_exec_a", bus.alu_a, 4'd7);
      check("add_exec_b", bus.alu_b, 4'd9);
      check("add_exec_op", bus.alu_opcode, OP_ADD);
      repeat (3) @(posedge clk); #1;
      check("halted_at_11", halted, 1'b0);
      @(posedge clk); #1;
      check("halted_at_12", halted, 1'b1);
      check_reg("add_r3_wrap", 3, 4'd0);
      check_reg("ldi_r1", 1, 4'd7);
      check_reg("ldi_r2", 2, 4'd9);
      // start from HALT, then a start pulse during EXEC
      pulse_start();
      check("restart_req", bus.imem_req, 1'b1);
      check("restart_addr", bus.imem_addr, 4'd0);
      check_reg("restart_r1", 1, 4'd7);
      check_reg("restart_r2", 2, 4'd9);
      repeat (2) @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      repeat (8) @(posedge clk); #1;
      check("exec_start_h11", halted, 1'b0);
      @(posedge clk); #1;
      check("exec_start_h12", halted, 1'b1);
      // reset in the middle of a fetch with ack high
      pulse_start();
      @(negedge clk); #1 rst = 1;
      #1;
      check("rst_req", bus.imem_req, 1'b0);
      check("rst_busy", busy, 1'b0);
      for (int r = 0; r < 4; r++) check_reg("rst_rf", 2'(r), 4'd0);
      @(negedge clk); #1 rst = 0;
      repeat (2) @(posedge clk); #1;
      check("post_rst_req", bus.imem_req, 1'b0);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_halted", halted, 1'b0);
      // countdown loop
      fill_hlt();
      mem[0] = ldi(0, 3); mem[1] = ldi(1, 1); mem[2] = alu(OP_SUB, 0, 0, 1); mem[3] = jnz(0, 2);
      clear_stats();
      pulse_start();
      wait_halt(100);
      check("sub_count", 16'(fcnt[2]), 16'd3);
      check("jnz_count", 16'(fcnt[3]), 16'd3);
      check("hlt_addr", last_addr, 4'd4);
      check_reg("countdown_r0", 0, 4'd0);
      // three wait cycles per fetch, stray acks outside fetch
      fill_hlt();
      mem[0] = ldi(0, 12); mem[1] = ldi(1, 10); mem[2] = alu(OP_AND, 2, 0, 1); mem[3] = alu(OP_OR, 3, 0, 1);
      ack_delay = 3; spurious = 1;
      pulse_start();
      repeat (29) @(posedge clk); #1;
      check("wait_h29", halted, 1'b0);
      @(posedge clk); #1;
      check("wait_h30", halted, 1'b1);
      check_reg("and_r2", 2, 4'd8);
      check_reg("or_r3", 3, 4'd14);
      ack_delay = 0; spurious = 0;
      // PC wrap: address 1 becomes HLT once the first pass is beyond it
      for (int k = 0; k < 16; k++) mem[k] = ldi(2'(k), 4'(k));
      clear_stats();
      pulse_start();
      for (int n = 0; n < 100 && fcnt[5] == 0; n++) @(posedge clk);
      #1 check("wrap_reached5", 16'(fcnt[5] != 0), 16'd1);
      mem[1] = HLT;
      wait_halt(200);
      check("wrap_after15", 16'(after15), 16'd0);
      check("wrap_fetch0", 16'(fcnt[0]), 16'd2);
      check("wrap_fetch1", 16'(fcnt[1]), 16'd2);
      check("wrap_fetch15", 16'(fcnt[15]), 16'd1);
      check_reg("wrap_r0", 0, 4'd0);
      check_reg("wrap_r1", 1, 4'd13);
      check_reg("wrap_r3", 3, 4'd15);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
